// File: rtl/aurora_link_supervisor_if.sv
// rtl/aurora_link_supervisor_if.sv - NFC request/acknowledge bundle between the link supervisor and the Aurora core
interface aurora_link_supervisor_if;
    logic       s_axi_nfc_req;
    logic [3:0] s_axi_nfc_nb;
    logic       s_axi_nfc_ack;

    // Supervisor side issues the request, the core acknowledges.
    modport master (
        output s_axi_nfc_req,
        output s_axi_nfc_nb,
        input  s_axi_nfc_ack
    );

    modport slave (
        input  s_axi_nfc_req,
        input  s_axi_nfc_nb,
        output s_axi_nfc_ack
    );
endinterface

// File: rtl/aurora_link_supervisor.sv
// rtl/aurora_link_supervisor.sv - Aurora 8b10b reset sequencing, bring-up supervision and NFC XOFF engine (optional stats: AURORA_SUP_STATS_EN)
module aurora_link_supervisor #(
    parameter int         NUM_LANES    = 1,
    parameter int         RESET_CYCLES = 128,
    parameter int         UP_TIMEOUT   = 1048576,
    parameter int         CNT_WIDTH    = 16,
    parameter logic [3:0] XOFF_NB      = 4'hF
) (
    input  logic                 user_clk,
    input  logic                 aresetn,
    input  logic                 ext_reset,
    input  logic [NUM_LANES-1:0] lane_up,
    input  logic                 channel_up,
    input  logic                 hard_err,
    input  logic                 soft_err,
    output logic                 gt_reset,
    output logic                 chan_reset,
    output logic                 link_ok,
    output logic [CNT_WIDTH-1:0] retry_count,
    output logic [CNT_WIDTH-1:0] drop_count,
    input  logic                 tx_nfc_xoff,
    aurora_link_supervisor_if.master nfc
`ifdef AURORA_SUP_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] soft_err_count,
    output logic [31:0]          up_cycles
`endif
);

    // One shared phase timer covers both reset phases and the bring-up window.
    localparam int TMR_MAX = (RESET_CYCLES > UP_TIMEOUT) ? RESET_CYCLES : UP_TIMEOUT;
    localparam int TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RESET_CYCLES - 1);
    localparam logic [TMR_W-1:0] UP_LAST  = TMR_W'(UP_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_GTRST,
        S_CHRST,
        S_WAIT,
        S_UP
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;

    logic all_up;
    logic link_drop;
    logic link_ok_nxt;
    logic up_entry;

    logic sent_xoff;
    logic req_xoff;

    // Link health and the value link_ok takes at the coming edge, shared by the NFC engine.
    always_comb begin
        all_up      = channel_up && (&lane_up);
        link_drop   = (state == S_UP) && (!all_up || hard_err);
        link_ok_nxt = (state == S_UP) && !link_drop && !ext_reset;
        up_entry    = !ext_reset && (state == S_WAIT) && all_up;
    end

    // Reset sequencing and bring-up supervision; ext_reset overrides every state.
    always_ff @(posedge user_clk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= S_GTRST;
            timer       <= '0;
            gt_reset    <= 1'b1;
            chan_reset  <= 1'b1;
            link_ok     <= 1'b0;
            retry_count <= '0;
            drop_count  <= '0;
        end else if (ext_reset) begin
            state      <= S_GTRST;
            timer      <= '0;
            gt_reset   <= 1'b1;
            chan_reset <= 1'b1;
            link_ok    <= 1'b0;
        end else begin
            case (state)
                S_GTRST: begin
                    if (timer == RST_LAST) begin
                        state    <= S_CHRST;
                        timer    <= '0;
                        gt_reset <= 1'b0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                S_CHRST: begin
                    if (timer == RST_LAST) begin
                        state      <= S_WAIT;
                        timer      <= '0;
                        chan_reset <= 1'b0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                S_WAIT: begin
                    // A link that comes up on the timeout cycle is accepted.
                    if (all_up) begin
                        state <= S_UP;
                        timer <= '0;
                    end else if (timer == UP_LAST) begin
                        state      <= S_GTRST;
                        timer      <= '0;
                        gt_reset   <= 1'b1;
                        chan_reset <= 1'b1;
                        if (retry_count != '1) begin
                            retry_count <= retry_count + CNT_ONE;
                        end
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                S_UP: begin
                    if (link_drop) begin
                        state      <= S_GTRST;
                        timer      <= '0;
                        gt_reset   <= 1'b1;
                        chan_reset <= 1'b1;
                        link_ok    <= 1'b0;
                        if (drop_count != '1) begin
                            drop_count <= drop_count + CNT_ONE;
                        end
                    end else begin
                        link_ok <= 1'b1;
                    end
                end
                default: begin
                    state      <= S_GTRST;
                    timer      <= '0;
                    gt_reset   <= 1'b1;
                    chan_reset <= 1'b1;
                    link_ok    <= 1'b0;
                end
            endcase
        end
    end

    // NFC engine: one request in flight, completes unchanged, far end assumed XON after link loss.
    always_ff @(posedge user_clk or negedge aresetn) begin
        if (!aresetn) begin
            nfc.s_axi_nfc_req <= 1'b0;
            nfc.s_axi_nfc_nb  <= 4'h0;
            sent_xoff         <= 1'b0;
            req_xoff          <= 1'b0;
        end else if (!link_ok_nxt) begin
            nfc.s_axi_nfc_req <= 1'b0;
            nfc.s_axi_nfc_nb  <= 4'h0;
            sent_xoff         <= 1'b0;
            req_xoff          <= 1'b0;
        end else if (nfc.s_axi_nfc_req) begin
            if (nfc.s_axi_nfc_ack) begin
                nfc.s_axi_nfc_req <= 1'b0;
                sent_xoff         <= req_xoff;
            end
        end else if (link_ok && (tx_nfc_xoff != sent_xoff)) begin
            // Dropping req on the ack edge guarantees a one-cycle gap before this re-issue.
            nfc.s_axi_nfc_req <= 1'b1;
            nfc.s_axi_nfc_nb  <= tx_nfc_xoff ? XOFF_NB : 4'h0;
            req_xoff          <= tx_nfc_xoff;
        end
    end

`ifdef AURORA_SUP_STATS_EN
    // Soft errors seen while up; survives link drops, cleared only by aresetn.
    always_ff @(posedge user_clk or negedge aresetn) begin
        if (!aresetn) begin
            soft_err_count <= '0;
        end else if ((state == S_UP) && soft_err && (soft_err_count != '1)) begin
            soft_err_count <= soft_err_count + CNT_ONE;
        end
    end

    // Residency counter for the current S_UP visit, restarted on each entry.
    always_ff @(posedge user_clk or negedge aresetn) begin
        if (!aresetn) begin
            up_cycles <= '0;
        end else if (up_entry) begin
            up_cycles <= '0;
        end else if (state == S_UP) begin
            up_cycles <= up_cycles + 32'd1;
        end
    end
`else
    logic unused_stats;
    assign unused_stats = soft_err ^ up_entry;
`endif

endmodule

// File: tb/tb_aurora_link_supervisor.sv
// tb/tb_aurora_link_supervisor.sv - scoreboard bench for aurora_link_supervisor
module tb_aurora_link_supervisor;

    localparam int NL = 4;

    logic user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    logic          aresetn, ext_reset, channel_up, hard_err, soft_err, tx_nfc_xoff, ack;
    logic [NL-1:0] lane_up;
    logic          gt_reset, chan_reset, link_ok;
    logic [15:0]   retry_count, drop_count;

    logic          s_gt, s_ch, s_ok;
    logic [1:0]    s_retry, s_drop;

`ifdef AURORA_SUP_STATS_EN
    logic [15:0]   soft_err_count;
    logic [31:0]   up_cycles;
    logic [1:0]    s_sec;
    logic [31:0]   s_upc;
`endif

    aurora_link_supervisor_if nfc_if ();
    aurora_link_supervisor_if sat_if ();
    assign nfc_if.s_axi_nfc_ack = ack;
    assign sat_if.s_axi_nfc_ack = 1'b0;

    aurora_link_supervisor #(
        .NUM_LANES(NL), .RESET_CYCLES(4), .UP_TIMEOUT(16), .CNT_WIDTH(16), .XOFF_NB(4'hF)
    ) u_dut (
        .user_clk(user_clk), .aresetn(aresetn), .ext_reset(ext_reset), .lane_up(lane_up),
        .channel_up(channel_up), .hard_err(hard_err), .soft_err(soft_err),
        .gt_reset(gt_reset), .chan_reset(chan_reset), .link_ok(link_ok),
        .retry_count(retry_count), .drop_count(drop_count),
        .tx_nfc_xoff(tx_nfc_xoff), .nfc(nfc_if.master)
`ifdef AURORA_SUP_STATS_EN
        , .soft_err_count(soft_err_count), .up_cycles(up_cycles)
`endif
    );

    aurora_link_supervisor #(
        .NUM_LANES(1), .RESET_CYCLES(4), .UP_TIMEOUT(16), .CNT_WIDTH(2), .XOFF_NB(4'hF)
    ) u_sat (
        .user_clk(user_clk), .aresetn(aresetn), .ext_reset(1'b0), .lane_up(1'b0),
        .channel_up(1'b0), .hard_err(1'b0), .soft_err(1'b0),
        .gt_reset(s_gt), .chan_reset(s_ch), .link_ok(s_ok),
        .retry_count(s_retry), .drop_count(s_drop),
        .tx_nfc_xoff(1'b0), .nfc(sat_if.master)
`ifdef AURORA_SUP_STATS_EN
        , .soft_err_count(s_sec), .up_cycles(s_upc)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0]  nb_q[$];
    logic [31:0] st_q[$];
    logic        sat_done = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge user_clk);
    endtask

    function automatic logic pick(input int s);
        case (s)
            0:       return link_ok;
            1:       return nfc_if.s_axi_nfc_req;
            default: return chan_reset;
        endcase
    endfunction

    // Bounded wait for a DUT level; an expired budget shows up as a failed check.
    task automatic wait_sig(input int s, input logic lvl, input int max, input string nm);
        int i = 0;
        while (pick(s) !== lvl && i < max) begin
            tick();
            i++;
        end
        chk(nm, 32'(pick(s)), 32'(lvl));
    endtask

    task automatic handshake(input int hold);
        wait_sig(1, 1'b1, 40, "req_rise");
        repeat (hold) begin
            tick();
            chk("req_held", 32'(nfc_if.s_axi_nfc_req), 32'd1);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("req_cleared_by_ack", 32'(nfc_if.s_axi_nfc_req), 32'd0);
    endtask

    // Monitor: pops the expected NFC code on each new request and status on each link_ok rise.
    logic       req_d = 1'b0, ok_d = 1'b0;
    logic [3:0] nb_d = 4'h0;
    always @(negedge user_clk) begin
        if (!aresetn) begin
            req_d <= 1'b0;
            ok_d  <= 1'b0;
        end else begin
            if (nfc_if.s_axi_nfc_req && !req_d) begin
                if (nb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL nfc_unexpected_req: got nb %0h, expected no request", nfc_if.s_axi_nfc_nb);
                end else begin
                    chk("nfc_nb", 32'(nfc_if.s_axi_nfc_nb), 32'(nb_q.pop_front()));
                end
            end
            if (nfc_if.s_axi_nfc_req && req_d) begin
                chk("nfc_nb_stable", 32'(nfc_if.s_axi_nfc_nb), 32'(nb_d));
            end
            if (link_ok && !ok_d) begin
                if (st_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL link_unexpected_up: got retry %0d drop %0d, expected link down", retry_count, drop_count);
                end else begin
                    chk("up_retry_drop", {retry_count, drop_count}, st_q.pop_front());
                end
`ifdef AURORA_SUP_STATS_EN
                chk("up_cycles_restart", up_cycles, 32'd1);
`endif
            end
            req_d <= nfc_if.s_axi_nfc_req;
            nb_d  <= nfc_if.s_axi_nfc_nb;
            ok_d  <= link_ok;
        end
    end

    // Saturation instance never sees the link come up: one timeout per 24 cycles.
    initial begin
        @(posedge aresetn);
        repeat (48) @(negedge user_clk);
        chk("sat_retry_2", 32'(s_retry), 32'd2);
        repeat (72) @(negedge user_clk);
        chk("sat_retry_stuck_3", 32'(s_retry), 32'd3);
        sat_done = 1'b1;
    end

    initial begin
        aresetn = 1'b0; ext_reset = 1'b0; channel_up = 1'b0; lane_up = '0;
        hard_err = 1'b0; soft_err = 1'b0; tx_nfc_xoff = 1'b0; ack = 1'b0;
        tick(3);
        chk("rst_gt_reset", 32'(gt_reset), 32'd1);
        chk("rst_chan_reset", 32'(chan_reset), 32'd1);
        chk("rst_link_ok", 32'(link_ok), 32'd0);
        chk("rst_counts", {retry_count, drop_count}, 32'd0);
        chk("rst_nfc", {nfc_if.s_axi_nfc_req, nfc_if.s_axi_nfc_nb}, 32'd0);

        // Bring-up: 4 cycles GT reset, 4 cycles channel reset, up at S_WAIT cycle 3.
        aresetn = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk("seq_gt_reset", 32'(gt_reset), 32'(i < 4));
            chk("seq_chan_reset", 32'(chan_reset), 32'(i < 8));
            tick();
        end
        tick();
        st_q.push_back({16'd0, 16'd0});
        channel_up = 1'b1; lane_up = '1;
        tick();
        chk("up_latency_0", 32'(link_ok), 32'd0);
        tick();
        chk("up_latency_1", 32'(link_ok), 32'd1);

        // ext_reset leaves S_UP without touching counters, then three timeouts.
        ext_reset = 1'b1; channel_up = 1'b0; lane_up = '0;
        tick(3);
        chk("ext_gt_reset", 32'(gt_reset), 32'd1);
        chk("ext_link_ok", 32'(link_ok), 32'd0);
        chk("ext_counts", {retry_count, drop_count}, 32'd0);
        ext_reset = 1'b0;
        tick(23);
        chk("to_still_wait", {gt_reset, chan_reset}, 32'd0);
        chk("to_retry_0", 32'(retry_count), 32'd0);
        tick();
        chk("to_gt_back", 32'(gt_reset), 32'd1);
        chk("to_retry_1", 32'(retry_count), 32'd1);
        tick(48);
        chk("to_retry_3", 32'(retry_count), 32'd3);
        st_q.push_back({16'd3, 16'd0});
        channel_up = 1'b1; lane_up = '1;
        wait_sig(0, 1'b1, 40, "reup_after_timeouts");

        // NFC: XOFF with 1-cycle latency, held 5 cycles until ack.
        tx_nfc_xoff = 1'b1; nb_q.push_back(4'hF);
        tick();
        chk("xoff_latency_req", 32'(nfc_if.s_axi_nfc_req), 32'd1);
        chk("xoff_latency_nb", 32'(nfc_if.s_axi_nfc_nb), 32'hF);
        handshake(5);
        tx_nfc_xoff = 1'b0; nb_q.push_back(4'h0);
        handshake(2);

        // XOFF outstanding while xoff drops: exactly one XON afterwards.
        tx_nfc_xoff = 1'b1; nb_q.push_back(4'hF); nb_q.push_back(4'h0);
        tick(2);
        tx_nfc_xoff = 1'b0;
        handshake(1);
        handshake(1);
        tick(10);
        chk("toggle_one_xon", 32'(nfc_if.s_axi_nfc_req), 32'd0);

        // Toggle and return before ack: no follow-up request.
        tx_nfc_xoff = 1'b1; nb_q.push_back(4'hF);
        tick(2);
        tx_nfc_xoff = 1'b0;
        tick();
        tx_nfc_xoff = 1'b1;
        handshake(1);
        tick(10);
        chk("toggle_return_none", 32'(nfc_if.s_axi_nfc_req), 32'd0);

        // Ack with no request outstanding is ignored.
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick(3);
        chk("stray_ack", 32'(nfc_if.s_axi_nfc_req), 32'd0);

        // Outstanding XOFF is cancelled by a channel drop, reissued after re-up.
        tx_nfc_xoff = 1'b0; nb_q.push_back(4'h0);
        handshake(1);
        tx_nfc_xoff = 1'b1; nb_q.push_back(4'hF);
        wait_sig(1, 1'b1, 20, "xoff_before_drop");
        channel_up = 1'b0;
        tick();
        chk("drop_req_cleared", {nfc_if.s_axi_nfc_req, nfc_if.s_axi_nfc_nb}, 32'd0);
        chk("drop_link_ok", 32'(link_ok), 32'd0);
        chk("drop_count_1", 32'(drop_count), 32'd1);
        channel_up = 1'b1;
        st_q.push_back({16'd3, 16'd1}); nb_q.push_back(4'hF);
        wait_sig(0, 1'b1, 40, "reup_after_drop");
        handshake(1);
        tx_nfc_xoff = 1'b0; nb_q.push_back(4'h0);
        handshake(1);

        // One-cycle hard error, then a single-lane drop.
        st_q.push_back({16'd3, 16'd2});
        hard_err = 1'b1;
        tick();
        hard_err = 1'b0;
        chk("hard_err_link_ok", 32'(link_ok), 32'd0);
        chk("hard_err_drop_2", 32'(drop_count), 32'd2);
        chk("hard_err_gt_reset", 32'(gt_reset), 32'd1);
        wait_sig(0, 1'b1, 40, "reup_after_hard_err");
        st_q.push_back({16'd3, 16'd3});
        lane_up = 4'b1011;
        tick();
        chk("lane2_link_ok", 32'(link_ok), 32'd0);
        chk("lane2_drop_3", 32'(drop_count), 32'd3);
        lane_up = '1;
        wait_sig(0, 1'b1, 40, "reup_after_lane2");

        // ext_reset pulse in the middle of S_WAIT restarts the sequence, counters untouched.
        ext_reset = 1'b1; channel_up = 1'b0;
        tick();
        ext_reset = 1'b0;
        wait_sig(2, 1'b0, 20, "reach_wait");
        tick(3);
        ext_reset = 1'b1;
        tick();
        ext_reset = 1'b0;
        chk("mid_wait_ext_resets", {gt_reset, chan_reset}, 32'd3);
        chk("mid_wait_ext_counts", {retry_count, drop_count}, {16'd3, 16'd3});
        tick(7);
        chk("mid_wait_chrst", 32'(chan_reset), 32'd1);
        tick();
        chk("mid_wait_rewait", 32'(chan_reset), 32'd0);
        st_q.push_back({16'd3, 16'd3});
        channel_up = 1'b1;
        wait_sig(0, 1'b1, 40, "reup_after_ext");

`ifdef AURORA_SUP_STATS_EN
        soft_err = 1'b1;
        tick(7);
        soft_err = 1'b0;
        tick();
        chk("soft_err_count_7", 32'(soft_err_count), 32'd7);
`endif

        tick(5);
        wait_sig(3, 1'b0, 1, "chan_reset_idle");
        begin
            int i = 0;
            while (!sat_done && i < 500) begin
                tick();
                i++;
            end
            chk("sat_finished", 32'(sat_done), 32'd1);
        end
        chk("nb_queue_drained", 32'(nb_q.size()), 32'd0);
        chk("status_queue_drained", 32'(st_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aurora_link_supervisor.md
Name: aurora_link_supervisor

Overview:
Parametrised per-link controller that sits between a wrapped Aurora 8b10b core and the user logic on the user_clk side. It has three jobs:
- Sequence the GT and channel resets.
- Supervise link bring-up, with a timeout and automatic retry, and count retries and link drops.
- Turn the level-sensitive tx_nfc_xoff request into Aurora NFC req/ack transactions.
It replaces the fixed reset, XOFF and status glue per core and supports multi-lane cores through NUM_LANES.

Parameters:
- NUM_LANES, 1, width of lane_up; the link counts as up only when all lanes are up.
- RESET_CYCLES, 128, cycles spent in each reset phase (min 2).
- UP_TIMEOUT, 1048576, cycles allowed in S_WAIT before retry (min 2).
- CNT_WIDTH, 16, width of the retry, drop and optional error counters.
- XOFF_NB, 4'hF, NFC nb code sent for XOFF; XON always sends 4'h0.

Ports:
- user_clk  in  1  single clock for all logic.
- aresetn  in  1  asynchronous, active-low reset.
- ext_reset  in  1  user_clk-synchronous request to restart the link (level).
- lane_up  in  NUM_LANES  per-lane up from core.
- channel_up  in  1  channel up from core.
- hard_err  in  1  core hard error.
- soft_err  in  1  core soft error.
- gt_reset  out  1  to core gt_reset.
- chan_reset  out  1  to core reset; its inverse is the user AXI4S reset.
- link_ok  out  1  link usable.
- retry_count  out  CNT_WIDTH  bring-up timeouts, saturating.
- drop_count  out  CNT_WIDTH  link losses from S_UP, saturating.
- tx_nfc_xoff  in  1  1 = stop the far-end transmitter.
- s_axi_nfc_req  out  1  NFC request to core.
- s_axi_nfc_nb  out  4  NFC code to core.
- s_axi_nfc_ack  in  1  NFC acknowledge from core.

Behaviour:
Reset values (aresetn=0):
- gt_reset=1, chan_reset=1, link_ok=0.
- retry_count=0, drop_count=0.
- s_axi_nfc_req=0, s_axi_nfc_nb=0, sent-state=XON.
- State S_GTRST, phase timer=0.
- All outputs are registered.

State machine:
- S_GTRST: gt_reset=1, chan_reset=1. After RESET_CYCLES cycles -> S_CHRST.
- S_CHRST: gt_reset=0, chan_reset=1. After RESET_CYCLES cycles -> S_WAIT.
- S_WAIT: both resets 0, timer runs.
  - If channel_up and &lane_up -> S_UP.
  - If the timer reaches UP_TIMEOUT-1 first -> retry_count+1, then S_GTRST.
  - If both happen in the same cycle, S_UP wins.
- S_UP: link_ok=1 from the cycle after entry. Any of !channel_up, !&lane_up or hard_err -> drop_count+1, link_ok=0 on the next edge, then S_GTRST.
- ext_reset=1 in any state: go to S_GTRST and clear the timer. No counter increments. While ext_reset is held, stay in S_GTRST with the timer held at 0.
- Counters saturate at all-ones; there is no wrap.

NFC engine (active only when link_ok=1):
- Desired state = tx_nfc_xoff.
- When no request is outstanding and desired != sent-state: on the next edge assert s_axi_nfc_req=1, with s_axi_nfc_nb = XOFF_NB if desired=1, else 4'h0. Latency is 1 cycle.
- req and nb stay stable until s_axi_nfc_ack=1 is sampled. On that edge: req=0 and sent-state updates to match nb.
- Minimum gap of 1 cycle between requests.
- If tx_nfc_xoff toggles while a request is outstanding, the outstanding request completes unchanged. Afterwards the latest level is compared again; a toggle and return before ack produces no further request.
- An ack while req=0 is ignored.
- If link_ok falls: req=0, nb=0, sent-state=XON in the same edge. The far end restarts in XON.

Optional Feature:
- Macro: AURORA_SUP_STATS_EN.
- When defined:
  - Adds output soft_err_count [CNT_WIDTH-1:0]. It increments once per cycle with soft_err=1 while in S_UP, saturates, and resets to 0 only on aresetn.
  - Adds output up_cycles [31:0], the number of cycles in the current S_UP residency. It clears on S_UP entry and wraps at 2^32.
- When undefined: neither port exists and no counter logic is generated. All other behaviour is identical.

Test Plan:
- Reset and bring-up, with RESET_CYCLES=4, UP_TIMEOUT=16:
  - Release aresetn -> gt_reset high for 4 cycles, then chan_reset high for 4 more.
  - Raise channel_up and lane_up at S_WAIT cycle 3 -> link_ok=1, retry_count=0.
- Timeout: hold channel_up=0 -> the 16th S_WAIT cycle returns to S_GTRST and retry_count=1. Three failures give 3. Then bring the link up -> link_ok=1.
- Drop: in S_UP, pulse hard_err for 1 cycle -> link_ok=0 on the next edge, drop_count=1, full reset sequence repeats. With NUM_LANES=4, dropping lane_up[2] alone gives drop_count=2.
- NFC handshake:
  - Raise tx_nfc_xoff -> req=1 and nb=4'hF next cycle, held for 5 cycles until ack.
  - Lower tx_nfc_xoff -> req with nb=4'h0.
  - Toggle xoff 1->0 during an outstanding XOFF -> exactly one XON request after the ack.
- NFC across drop and ext_reset:
  - With an XOFF request outstanding, drop channel_up -> req=0 next edge.
  - After re-up with tx_nfc_xoff still 1 -> a new XOFF request is issued.
  - An ext_reset pulse mid-S_WAIT restarts S_GTRST with no counter change.
- Saturation and stats:
  - CNT_WIDTH=2 -> retry_count stops at 3 after 5 timeouts.
  - With AURORA_SUP_STATS_EN, 7 soft_err cycles in S_UP -> soft_err_count=7, and up_cycles restarts from 0 on re-entry.
